// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding and
// requester index constants used by the pointer logic.
// Latency: n/a (types and constants only). Backpressure: n/a.
package ram_arb_pkg;

  // START: one-cycle post-reset state
  // CLEAR: optional RAM sweep
  // ARB:   normal arbitration
  typedef enum logic [1:0] {
    START = 2'd0,
    CLEAR = 2'd1,
    ARB   = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant selector. It looks only at the current
// valids and the priority pointer; the pointer itself is owned by the caller.
// Latency: purely combinational. Backpressure: an ungranted valid simply sees no grant.
//
// Ports:
//   i_valid[1:0]  request valids (bit N = requester N)
//   i_ptr         requester that wins when both requests are valid
//   o_grant[1:0]  one-hot grant, all zero when nothing is valid
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_ptr == REQ1) ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter/sequencer that shares one single-port sync-read RAM
// between two requesters. The RAM can optionally be swept to CLEAR_VALUE
// after reset; that sweep is enabled by defining RAM_ARB_CLEAR_EN.
// Latency: grant is combinational; read data returns one cycle after acceptance.
// Backpressure: rN_ready is low while the other requester wins or outside ARB;
//               a held-off requester keeps valid and payload stable.
//
// Ports:
//   clock, reset_n            single clock, asynchronous active-low reset
//   rN_valid/ready            request handshake, accepted on valid & ready
//   rN_we/addr/wdata          access type, address and write data
//   rN_rvalid/rdata           one-cycle read response (rdata is 0 otherwise)
//   ram_addr/din/we, ram_dout RAM interface (registered address, 1-cycle read)
//   busy                      high while the FSM is not in ARB
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int                AWIDTH      = 3,
  parameter int                DWIDTH      = 32,
  parameter logic [DWIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [AWIDTH-1:0] r0_addr,
  input  logic [DWIDTH-1:0] r0_wdata,
  output logic              r0_rvalid,
  output logic [DWIDTH-1:0] r0_rdata,

  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [AWIDTH-1:0] r1_addr,
  input  logic [DWIDTH-1:0] r1_wdata,
  output logic              r1_rvalid,
  output logic [DWIDTH-1:0] r1_rdata,

  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,

  output logic              busy
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_ptr;
  logic [1:0] r_rvalid;
  logic       w_in_arb;
  logic [1:0] w_valid;
  logic [1:0] w_grant;

  assign w_in_arb = (r_state == ARB);

  // Requests are masked outside ARB so no grant can leak during START/CLEAR.
  assign w_valid = {r1_valid, r0_valid} & {2{w_in_arb}};

  rr_arb2 u_rr_arb2 (
    .i_valid (w_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign r0_ready = w_grant[0];
  assign r1_ready = w_grant[1];

`ifdef RAM_ARB_CLEAR_EN
  localparam int                DEPTH     = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  logic [AWIDTH-1:0] r_cnt;

  // Sweep address; reset returns it to 0 so an interrupted sweep restarts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state == CLEAR) begin
      r_cnt <= r_cnt + AWIDTH'(1);
    end
  end
`else
  logic w_unused_clear;
  assign w_unused_clear = ^CLEAR_VALUE;
`endif

  // State register, priority pointer and read-response strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= START;
      r_ptr    <= REQ0;
      r_rvalid <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      // Hand priority to the requester that lost (or was idle) this time.
      if (|w_grant) begin
        r_ptr <= w_grant[0] ? REQ1 : REQ0;
      end
      // Only reads produce a response, one cycle after acceptance.
      r_rvalid <= w_grant & ~{r1_we, r0_we};
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      START: begin
`ifdef RAM_ARB_CLEAR_EN
        w_state_nxt = CLEAR;
`else
        w_state_nxt = ARB;
`endif
      end
`ifdef RAM_ARB_CLEAR_EN
      CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ARB;
        end
      end
`endif
      ARB:     w_state_nxt = ARB;
      default: w_state_nxt = START;
    endcase
  end

  // RAM drive. With no grant the address/data buses idle on requester 0's
  // payload and the write enable stays low.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = r0_addr;
    ram_din  = r0_wdata;
`ifdef RAM_ARB_CLEAR_EN
    if (r_state == CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = r_cnt;
      ram_din  = CLEAR_VALUE;
    end else
`endif
    if (w_grant[1]) begin
      ram_we   = r1_we;
      ram_addr = r1_addr;
      ram_din  = r1_wdata;
    end else if (w_grant[0]) begin
      ram_we   = r0_we;
    end
  end

  assign r0_rvalid = r_rvalid[0];
  assign r1_rvalid = r_rvalid[1];
  assign r0_rdata  = r_rvalid[0] ? ram_dout : '0;
  assign r1_rdata  = r_rvalid[1] ? ram_dout : '0;

  assign busy = ~w_in_arb;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Self-checking bench for ram_arbiter_2p: table of per-cycle request vectors
// with hand-derived grants, a reference memory, and a response queue.
// Works with or without RAM_ARB_CLEAR_EN defined.
module tb_ram_arbiter_2p;

`ifdef RAM_ARB_CLEAR_EN
  localparam int CLR_CYC = 8;
`else
  localparam int CLR_CYC = 0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        r0_valid, r0_ready, r0_we, r0_rvalid;
  logic [2:0]  r0_addr;
  logic [31:0] r0_wdata, r0_rdata;
  logic        r1_valid, r1_ready, r1_we, r1_rvalid;
  logic [2:0]  r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
  logic [2:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        ram_we;
  logic        busy;

  always #5 clock = ~clock;

  ram_arbiter_2p #(.AWIDTH(3), .DWIDTH(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .busy      (busy)
  );

  // Single-port RAM: registered address, one-cycle read.
  logic [31:0] mem [8];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Reference contents tracked from expected grants.
  logic [31:0] refmem [8];

  typedef struct {
    logic        v0, we0;
    logic [2:0]  a0;
    logic [31:0] d0;
    logic        v1, we1;
    logic [2:0]  a1;
    logic [31:0] d1;
    int          g;     // expected grant: 0 none, 1 r0, 2 r1
  } vec_t;

  typedef struct {
    int          who;
    logic [31:0] dat;
  } rsp_t;

  rsp_t sbq[$];
  vec_t tv[19];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic v0, input logic we0, input logic [2:0] a0,
                              input logic [31:0] d0, input logic v1, input logic we1,
                              input logic [2:0] a1, input logic [31:0] d1, input int g);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.g  = g;
    return v;
  endfunction

  function automatic logic [31:0] init_word(input int i);
`ifdef RAM_ARB_CLEAR_EN
    return 32'h0;
`else
    return 32'h5A00_0000 | 32'(i);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Compare the response strobes against what the previous cycle accepted.
  task automatic check_resp();
    rsp_t e;
    logic [31:0] ed0, ed1;
    logic ev0, ev1;
    ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.who == 0) begin ev0 = 1'b1; ed0 = e.dat; end
      else            begin ev1 = 1'b1; ed1 = e.dat; end
    end
    chk("r0_rvalid", 32'(r0_rvalid), 32'(ev0));
    chk("r0_rdata",  r0_rdata, ed0);
    chk("r1_rvalid", 32'(r1_rvalid), 32'(ev1));
    chk("r1_rdata",  r1_rdata, ed1);
  endtask

  task automatic apply(input vec_t v);
    logic        ewe;
    logic [2:0]  ea;
    logic [31:0] ed;
    @(negedge clock);
    check_resp();
    r0_valid = v.v0; r0_we = v.we0; r0_addr = v.a0; r0_wdata = v.d0;
    r1_valid = v.v1; r1_we = v.we1; r1_addr = v.a1; r1_wdata = v.d1;
    #1;
    ewe = 1'b0; ea = v.a0; ed = v.d0;
    if (v.g == 1) ewe = v.we0;
    if (v.g == 2) begin ewe = v.we1; ea = v.a1; ed = v.d1; end
    chk("r0_ready", 32'(r0_ready), 32'(v.g == 1));
    chk("r1_ready", 32'(r1_ready), 32'(v.g == 2));
    chk("ram_we",   32'(ram_we), 32'(ewe));
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    chk("ram_din",  ram_din, ed);
    if (v.g != 0) begin
      if (ewe) refmem[ea] = ed;
      else     sbq.push_back('{who: v.g - 1, dat: refmem[ea]});
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i]    = 32'h5A00_0000 | 32'(i);
      refmem[i] = init_word(i);
    end

    // Vectors start with ptr = 0 after reset.
    tv[0]  = mk(1,1,3'd5,32'hDEADBEEF, 0,0,3'd0,32'h0, 1); // r0 write 5
    tv[1]  = mk(1,0,3'd5,32'h0,        0,0,3'd0,32'h0, 1); // r0 read 5 (RAW)
    tv[2]  = mk(0,0,3'd0,32'h0,        0,0,3'd0,32'h0, 0); // idle, ptr=1
    tv[3]  = mk(0,0,3'd0,32'h0,        1,0,3'd2,32'h0, 2); // r1 alone -> ptr=0
    tv[4]  = mk(1,0,3'd1,32'h0,        1,0,3'd2,32'h0, 1); // alternate
    tv[5]  = mk(1,0,3'd1,32'h0,        1,0,3'd2,32'h0, 2);
    tv[6]  = mk(1,0,3'd1,32'h0,        1,0,3'd2,32'h0, 1);
    tv[7]  = mk(1,0,3'd1,32'h0,        1,0,3'd2,32'h0, 2);
    tv[8]  = mk(0,0,3'd0,32'h0,        1,0,3'd4,32'h0, 2); // r1 alone x3
    tv[9]  = mk(0,0,3'd0,32'h0,        1,0,3'd4,32'h0, 2);
    tv[10] = mk(0,0,3'd0,32'h0,        1,0,3'd4,32'h0, 2);
    tv[11] = mk(1,0,3'd6,32'h0,        1,0,3'd4,32'h0, 1); // ptr=0 -> r0
    tv[12] = mk(1,1,3'd3,32'h11,       1,0,3'd3,32'h0, 2); // ptr=1: r1 read old
    tv[13] = mk(1,1,3'd3,32'h11,       0,0,3'd0,32'h0, 1); // held write lands
    tv[14] = mk(0,0,3'd0,32'h0,        1,0,3'd3,32'h0, 2); // r1 sees 0x11
    tv[15] = mk(1,0,3'd7,32'h0,        1,1,3'd7,32'hCAFEF00D, 1); // ptr=0
    tv[16] = mk(0,0,3'd0,32'h0,        1,1,3'd7,32'hCAFEF00D, 2); // r1 write
    tv[17] = mk(1,0,3'd7,32'h0,        0,0,3'd0,32'h0, 1); // r0 reads new
    tv[18] = mk(0,0,3'd0,32'h0,        0,0,3'd0,32'h0, 0); // drain

    // Reset with a request already pending: nothing may be granted.
    reset_n  = 1'b0;
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 3'd0; r0_wdata = '0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = 3'd0; r1_wdata = '0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_busy",     32'(busy), 32'd1);
    chk("rst_r0_ready", 32'(r0_ready), 32'd0);
    chk("rst_rvalid",   32'({r1_rvalid, r0_rvalid}), 32'd0);
    chk("rst_rdata",    r0_rdata | r1_rdata, 32'd0);
    chk("rst_ram_we",   32'(ram_we), 32'd0);

    reset_n = 1'b1;
    #1;
    chk("start_busy",   32'(busy), 32'd1);
    chk("start_ready",  32'(r0_ready), 32'd0);
    chk("start_ram_we", 32'(ram_we), 32'd0);
    for (int c = 1; c <= CLR_CYC; c++) begin
      @(negedge clock); #1;
      chk("clr_busy",  32'(busy), 32'd1);
      chk("clr_ready", 32'(r0_ready), 32'd0);
      chk("clr_we",    32'(ram_we), 32'd1);
      chk("clr_addr",  32'(ram_addr), 32'(c - 1));
      chk("clr_din",   ram_din, 32'd0);
    end
    @(negedge clock); #1;
    chk("first_ready", 32'(r0_ready), 32'd1);
    chk("first_busy",  32'(busy), 32'd0);
    r0_valid = 1'b0;

    for (int i = 0; i < 19; i++) apply(tv[i]);

    // Reset between read acceptance and its response.
    @(negedge clock);
    check_resp();
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 3'd1;
    r1_valid = 1'b0;
    #1;
    chk("mid_ready", 32'(r0_ready), 32'd1);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rvalid", 32'(r0_rvalid), 32'd0);
    chk("mid_rdata",  r0_rdata, 32'd0);
    chk("mid_busy",   32'(busy), 32'd1);
    chk("mid_ready0", 32'(r0_ready), 32'd0);
    r0_valid = 1'b0;
    @(negedge clock);
    chk("mid_rvalid2", 32'(r0_rvalid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("mid_start_busy", 32'(busy), 32'd1);
    @(negedge clock); #1;
`ifdef RAM_ARB_CLEAR_EN
    chk("mid_clr_addr0", 32'(ram_addr), 32'd0);
    chk("mid_clr_we",    32'(ram_we), 32'd1);
`else
    chk("mid_arb_busy",  32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
